// File: rtl/rr_arb4_if.sv
// Handshake bundle between the round-robin arbiter and its downstream mux/consumer.
// Carries request lines, the grant presentation and the transfer count.
interface rr_arb4_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       req;
    logic             out_ready;
    logic [1:0]       sel;
    logic [3:0]       grant;
    logic             out_valid;
    logic [CNT_W-1:0] xfer_cnt;

    modport master (
        input  req,
        input  out_ready,
        output sel,
        output grant,
        output out_valid,
        output xfer_cnt
    );

    modport slave (
        output req,
        output out_ready,
        input  sel,
        input  grant,
        input  out_valid,
        input  xfer_cnt
    );
endinterface

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter driving a mux4 select with a valid/ready handshake.
// All outputs are registered; one IDLE cycle separates consecutive grants.
module rr_arb4 #(
    parameter int CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arb4_if.master    bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    logic [3:0]       r_grant;
    logic [3:0]       w_grant_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_pick;
    logic [1:0]       w_idx;

    // Scan from farthest to nearest so the closest set bit after ptr wins.
    always_comb begin
        w_pick = r_ptr;
        w_idx  = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            w_idx = r_ptr + 2'(i);
            if (bus.req[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_grant_nxt = r_grant;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_sel_nxt   = w_pick;
                    w_grant_nxt = 4'b0001 << w_pick;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (bus.out_ready) begin
                    w_ptr_nxt   = r_sel + 2'd1;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_valid_nxt = 1'b0;
                    w_grant_nxt = 4'b0000;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_grant <= 4'b0000;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_grant <= w_grant_nxt;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.sel       = r_sel;
    assign bus.grant     = r_grant;
    assign bus.out_valid = r_valid;
    assign bus.xfer_cnt  = r_cnt;

endmodule
